// File: rtl/clk_div_pkg.sv
// Shared types for the clock-enable divider bank: output mode, per-channel config, select width.
// Divider fields are carried at DIV_W_MAX bits; channel DIV_W must not exceed it.
package clk_div_pkg;

    localparam int unsigned DIV_W_MAX = 16;

    typedef enum logic {
        MODE_TICK   = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        mode_e                mode;
    } ch_cfg_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter, shadowed div/mode applied at period boundaries,
// registered tick and square enables. Optional phase-align input under CLK_DIV_SYNC_EN.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic             i_wr_mode,
    input  logic             i_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             i_sync,
`endif
    output logic             o_pending,
    output logic             o_tick,
    output logic             o_out
);

    logic [DIV_W-1:0] r_cnt;
    ch_cfg_t          r_cfg;
    ch_cfg_t          r_shadow;
    logic             r_pending;
    logic             r_tick;
    logic             r_sq;

    ch_cfg_t          w_wr_cfg;
    ch_cfg_t          w_next_cfg;
    logic             w_wrap;
    logic             w_sync;
    logic             w_boundary;

    always_comb begin
        w_wr_cfg.div  = DIV_W_MAX'(i_wr_div);
        w_wr_cfg.mode = mode_e'(i_wr_mode);
        w_wrap        = (DIV_W_MAX'(r_cnt) == r_cfg.div);
`ifdef CLK_DIV_SYNC_EN
        w_sync        = i_sync & i_en;
`else
        w_sync        = 1'b0;
`endif
        // A disabled channel is always at a boundary, so writes and pending shadows land at once.
        w_boundary    = ~i_en | w_sync | w_wrap;
        w_next_cfg    = r_cfg;
        if (i_wr) begin
            w_next_cfg = w_wr_cfg;
        end else if (r_pending) begin
            w_next_cfg = r_shadow;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_cfg     <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_cfg     <= w_next_cfg;
                r_pending <= 1'b0;
            end else if (i_wr) begin
                r_shadow  <= w_wr_cfg;
                r_pending <= 1'b1;
            end
            if (w_boundary) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_tick <= i_en & w_wrap & ~w_sync;
            r_sq   <= i_en & (DIV_W_MAX'(r_cnt) > (r_cfg.div >> 1));
        end
    end

    assign o_pending = r_pending;
    assign o_tick    = r_tick;
    assign o_out     = (r_cfg.mode == MODE_SQUARE) ? r_sq : r_tick;

endmodule

// File: rtl/clk_div_bank.sv
// NUM_CH independent programmable clock-enable dividers behind a single write port.
// Define CLK_DIV_SYNC_EN to add i_sync, which restarts all enabled channels in phase.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned CH_W   = ch_w(NUM_CH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [CH_W-1:0]   i_wr_ch,
    input  logic [DIV_W-1:0]  i_wr_div,
    input  logic              i_wr_mode,
    input  logic [NUM_CH-1:0] i_en,
`ifdef CLK_DIV_SYNC_EN
    input  logic              i_sync,
`endif
    output logic [NUM_CH-1:0] o_pending,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_out
);

    logic [NUM_CH-1:0] w_wr_sel;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Select values >= NUM_CH match no channel and are dropped.
        assign w_wr_sel[g] = i_wr & (i_wr_ch == CH_W'(g));

        clk_div_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr      (w_wr_sel[g]),
            .i_wr_div  (i_wr_div),
            .i_wr_mode (i_wr_mode),
            .i_en      (i_en[g]),
`ifdef CLK_DIV_SYNC_EN
            .i_sync    (i_sync),
`endif
            .o_pending (o_pending[g]),
            .o_tick    (o_tick[g]),
            .o_out     (o_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank against a period-position reference model,
// plus directed checks of first-tick latency and square-wave shape.
module tb_clk_div_bank;

    localparam int unsigned NCH  = 3;
    localparam int unsigned DW   = 4;
    localparam int unsigned CW   = 2;

    logic           clk;
    logic           rst;
    logic           wr;
    logic [CW-1:0]  wr_ch;
    logic [DW-1:0]  wr_div;
    logic           wr_mode;
    logic [NCH-1:0] en;
    logic           sync;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] out;

    int n_checks;
    int n_fail;

    // Model: position within the current period, applied and shadowed settings.
    int m_pos   [NCH];
    int m_div   [NCH];
    int m_mode  [NCH];
    int m_sdiv  [NCH];
    int m_smode [NCH];
    bit m_pend  [NCH];
    logic [NCH-1:0] exp_tick;
    logic [NCH-1:0] exp_out;
    logic [NCH-1:0] exp_pend;

    clk_div_bank #(
        .NUM_CH (NCH),
        .DIV_W  (DW)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr      (wr),
        .i_wr_ch   (wr_ch),
        .i_wr_div  (wr_div),
        .i_wr_mode (wr_mode),
        .i_en      (en),
`ifdef CLK_DIV_SYNC_EN
        .i_sync    (sync),
`endif
        .o_pending (pending),
        .o_tick    (tick),
        .o_out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pos[c] = 0; m_div[c] = 0; m_mode[c] = 0;
            m_sdiv[c] = 0; m_smode[c] = 0; m_pend[c] = 0;
        end
        exp_tick = '0; exp_out = '0; exp_pend = '0;
    endtask

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int  period;
            bit  last;
            bit  hi;
            bit  sel;
            bit  bnd;
            period = m_div[c] + 1;
            last   = (m_pos[c] == period - 1);
            // Square is high for the final floor(period/2) positions of each period.
            hi     = (m_pos[c] >= period - period / 2);
            sel    = wr && (int'(wr_ch) == c);
            exp_tick[c] = en[c] && last;
            bnd    = !en[c] || last;
            if (bnd) begin
                if (sel) begin
                    m_div[c] = int'(wr_div); m_mode[c] = int'(wr_mode);
                end else if (m_pend[c]) begin
                    m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c];
                end
                m_pend[c] = 0;
                m_pos[c]  = 0;
            end else begin
                if (sel) begin
                    m_sdiv[c] = int'(wr_div); m_smode[c] = int'(wr_mode); m_pend[c] = 1;
                end
                m_pos[c] = m_pos[c] + 1;
            end
            exp_out[c]  = (m_mode[c] != 0) ? (en[c] && hi) : exp_tick[c];
            exp_pend[c] = m_pend[c];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("tick", 32'(tick), 32'(exp_tick));
        check("out", 32'(out), 32'(exp_out));
        check("pending", 32'(pending), 32'(exp_pend));
    endtask

    // Asynchronous assert mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_async_tick", 32'(tick), 32'd0);
        check("rst_async_out", 32'(out), 32'd0);
        check("rst_async_pending", 32'(pending), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle_inputs();
        wr = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
    endtask

    initial begin
        int first;
        int pulses;
        bit pat [5];
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        sync = 1'b0;
        en   = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_out", 32'(out), 32'd0);
        check("reset_pending", 32'(pending), 32'd0);
        rst = 1'b0;

        // ch0 div=3 tick mode, written while disabled.
        wr = 1'b1; wr_ch = 2'd0; wr_div = 4'd3; wr_mode = 1'b0;
        step();
        check("ch0_no_pending_when_disabled", 32'(pending[0]), 32'd0);
        idle_inputs();
        en[0] = 1'b1;
        first  = 0;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (tick[0]) begin
                pulses++;
                if (first == 0) first = k;
            end
            check("ch0_out_eq_tick", 32'(out[0]), 32'(tick[0]));
        end
        check("ch0_first_tick_edge", 32'(first), 32'd4);
        check("ch0_pulse_count", 32'(pulses), 32'd3);

        // ch1 div=4 square mode: 3 low, 2 high.
        pat[0] = 0; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        wr = 1'b1; wr_ch = 2'd1; wr_div = 4'd4; wr_mode = 1'b1;
        step();
        idle_inputs();
        en[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("ch1_square_pattern", 32'(out[1]), 32'(pat[k % 5]));
        end

        // Out-of-range select must leave every channel untouched.
        wr = 1'b1; wr_ch = 2'd3; wr_div = 4'd1; wr_mode = 1'b1;
        step();
        check("oor_no_pending", 32'(pending), 32'd0);
        idle_inputs();

        for (int n = 0; n < 3000; n++) begin
            wr      = ($urandom_range(0, 3) == 0);
            wr_ch   = CW'($urandom_range(0, 3));
            wr_div  = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1)) : DW'($urandom);
            wr_mode = 1'($urandom);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
            end
            if ($urandom_range(0, 699) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        idle_inputs();
        do_reset();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
